// File: rtl/uart_tx_drain_if.sv
// Read handshake between the io881 output FIFO (master) and the serial drain (slave).
interface uart_tx_drain_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             d_ready;
  logic             d_strobe;

  modport master (output d, output d_ready, input d_strobe);
  modport slave  (input d, input d_ready, output d_strobe);
endinterface

// File: rtl/uart_tx_drain.sv
// Drains the io881 output FIFO one word per frame and serialises it as
// start / data LSB-first / optional parity / stop on txd.
module uart_tx_drain #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_drain_if.slave fifo,
  input  logic           enable,
  output logic           txd,
  output logic           busy
);

  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam bit          PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD = (PARITY == 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_strobe;
  logic             w_tick;
  logic             w_accept;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_accept = enable && fifo.d_ready && !rst;

  // Next-state, counters, capture and the combinational FIFO read strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_strobe    = 1'b0;

    if (r_state != IDLE) begin
      w_div_nxt = w_tick ? '0 : DIV_W'(r_div + 1'b1);
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_strobe    = 1'b1;
          w_state_nxt = START;
          w_shift_nxt = fifo.d;
          w_par_nxt   = PAR_ODD ? ~(^fifo.d) : (^fifo.d);
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_bit_nxt = '0;
            if (PAR_EN) w_state_nxt = PAR;
            else        w_state_nxt = STOP;
          end else begin
            w_bit_nxt = BIT_W'(r_bit + 1'b1);
          end
        end
      end
      PAR: begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_bit_nxt   = '0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit == STOP_LAST) begin
            w_bit_nxt = '0;
            // Final stop cycle doubles as an accept slot for gap-free frames.
            if (w_accept) begin
              w_strobe    = 1'b1;
              w_state_nxt = START;
              w_shift_nxt = fifo.d;
              w_par_nxt   = PAR_ODD ? ~(^fifo.d) : (^fifo.d);
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_bit_nxt = BIT_W'(r_bit + 1'b1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase

    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      PAR:     w_txd_nxt = w_par_nxt;
      default: w_txd_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign fifo.d_strobe = w_strobe;
  assign txd           = r_txd;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three instances (no/odd/even parity) share one stimulus
// and are checked every cycle against a frame-level model plus literal expectations.
module tb_uart_tx_drain;

  localparam int unsigned W    = 8;
  localparam int unsigned CPB  = 4;
  localparam int          LOGN = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         d_ready;
  logic [W-1:0] d;

  always #5 clk = ~clk;

  uart_tx_drain_if #(.WIDTH(W)) if0 ();
  uart_tx_drain_if #(.WIDTH(W)) if1 ();
  uart_tx_drain_if #(.WIDTH(W)) if2 ();

  assign if0.d = d;
  assign if1.d = d;
  assign if2.d = d;
  assign if0.d_ready = d_ready;
  assign if1.d_ready = d_ready;
  assign if2.d_ready = d_ready;

  logic [2:0] txd_v, busy_v, stb_v;
  assign stb_v = {if2.d_strobe, if1.d_strobe, if0.d_strobe};

  uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .fifo(if0), .enable(en), .txd(txd_v[0]), .busy(busy_v[0]));
  uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .fifo(if1), .enable(en), .txd(txd_v[1]), .busy(busy_v[1]));
  uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .fifo(if2), .enable(en), .txd(txd_v[2]), .busy(busy_v[2]));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: instance k uses parity mode k; a frame is a list of bit slots.
  bit   m_act  [3];
  int   m_t    [3];
  int   m_len  [3];
  logic m_bits [3][0:15];

  logic [2:0] log_txd  [0:LOGN-1];
  logic [2:0] log_busy [0:LOGN-1];
  logic [2:0] log_stb  [0:LOGN-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_frame(int k, logic [W-1:0] w);
    int n;
    m_bits[k][0] = 1'b0;
    for (int i = 0; i < W; i++) m_bits[k][1+i] = w[i];
    n = 1 + W;
    if (k != 0) begin
      m_bits[k][n] = (k == 2) ? (^w) : ~(^w);
      n++;
    end
    m_bits[k][n] = 1'b1;
    n++;
    m_len[k] = n * CPB;
    m_t[k]   = 0;
    m_act[k] = 1'b1;
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    logic e_txd, e_busy, e_stb;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        e_txd = 1'b1; e_busy = 1'b0; e_stb = 1'b0;
      end else begin
        e_busy = m_act[k];
        e_txd  = m_act[k] ? m_bits[k][m_t[k] / CPB] : 1'b1;
        e_stb  = (!m_act[k] || (m_t[k] == m_len[k] - 1)) && en && d_ready;
      end
      chk($sformatf("txd[%0d]", k),    txd_v[k],  e_txd);
      chk($sformatf("busy[%0d]", k),   busy_v[k], e_busy);
      chk($sformatf("strobe[%0d]", k), stb_v[k],  e_stb);
      if (cyc < LOGN) begin
        log_txd[cyc][k]  = txd_v[k];
        log_busy[cyc][k] = busy_v[k];
        log_stb[cyc][k]  = stb_v[k];
      end
      if (rst) m_act[k] = 1'b0;
      else if (e_stb) load_frame(k, d);
      else if (m_act[k]) begin
        m_t[k]++;
        if (m_t[k] == m_len[k]) m_act[k] = 1'b0;
      end
    end
  end

  // sel: 0 = txd, 1 = busy, 2 = strobe
  task automatic lit(string nm, int sel, int k, int t, logic exp);
    logic act;
    case (sel)
      0:       act = log_txd[t][k];
      1:       act = log_busy[t][k];
      default: act = log_stb[t][k];
    endcase
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d cycle %0d): got %b expected %b", nm, k, t, act, exp);
    end
  endtask

  function automatic int cnt_stb(int k, int a, int b);
    int c = 0;
    for (int t = a; t <= b; t++) if (log_stb[t][k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_txd_low(int k, int a, int b);
    int c = 0;
    for (int t = a; t <= b; t++) if (log_txd[t][k] !== 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_busy_low(int k, int a, int b);
    int c = 0;
    for (int t = a; t <= b; t++) if (log_busy[t][k] !== 1'b1) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0, t1, ts, te;

  initial begin
    rst = 1'b1; en = 1'b1; d_ready = 1'b0; d = '0;
    #2;
    chk("reset_txd0", txd_v[0], 1'b1);
    chk("reset_busy0", busy_v[0], 1'b0);
    chk("reset_stb0", stb_v[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) tick();

    // Single frame; d changes after accept and must not leak into txd.
    t0 = cyc; d = 8'hA5; d_ready = 1'b1;
    tick();
    d_ready = 1'b0; d = 8'h3C;
    repeat (50) tick();
    lit("sf_stb",      2, 0, t0,      1'b1);
    lit("sf_stb_once", 2, 0, t0 + 1,  1'b0);
    lit("sf_idle_txd", 0, 0, t0,      1'b1);
    lit("sf_start_a",  0, 0, t0 + 1,  1'b0);
    lit("sf_start_b",  0, 0, t0 + 4,  1'b0);
    lit("sf_bit0",     0, 0, t0 + 5,  1'b1);
    lit("sf_bit1",     0, 0, t0 + 9,  1'b0);
    lit("sf_bit6",     0, 0, t0 + 29, 1'b0);
    lit("sf_bit7",     0, 0, t0 + 33, 1'b1);
    lit("sf_stop",     0, 0, t0 + 37, 1'b1);
    lit("sf_busy_end", 1, 0, t0 + 40, 1'b1);
    lit("sf_busy_off", 1, 0, t0 + 41, 1'b0);
    lit("par_even",    0, 2, t0 + 37, 1'b0);
    lit("par_odd",     0, 1, t0 + 37, 1'b1);
    lit("par_stop",    0, 2, t0 + 41, 1'b1);
    lit("par_busy",    1, 2, t0 + 44, 1'b1);
    lit("par_busy_off",1, 2, t0 + 45, 1'b0);

    // Back-to-back: FIFO presents 01 then FF with d_ready held through cycle t0+40.
    t0 = cyc; d = 8'h01; d_ready = 1'b1;
    tick();
    d = 8'hFF;
    repeat (40) tick();
    d_ready = 1'b0;
    repeat (50) tick();
    lit("b2b_stb2",     2, 0, t0 + 40, 1'b1);
    lit("b2b_stop1",    0, 0, t0 + 37, 1'b1);
    lit("b2b_start2_a", 0, 0, t0 + 41, 1'b0);
    lit("b2b_start2_b", 0, 0, t0 + 44, 1'b0);
    lit("b2b_bit0",     0, 0, t0 + 45, 1'b1);
    lit("b2b_busy_off", 1, 0, t0 + 81, 1'b0);
    chk_int("b2b_busy_gaps", cnt_busy_low(0, t0 + 1, t0 + 80), 0);
    chk_int("b2b_stb_count", cnt_stb(0, t0, t0 + 90), 2);

    // Enable gating: held off, then released, then dropped mid-frame.
    en = 1'b0; d = 8'h5A; d_ready = 1'b1; ts = cyc;
    repeat (20) tick();
    en = 1'b1; te = cyc;
    repeat (10) tick();
    en = 1'b0;
    repeat (50) tick();
    d_ready = 1'b0; en = 1'b1;
    repeat (5) tick();
    chk_int("en_off_stb",  cnt_stb(0, ts, te - 1), 0);
    chk_int("en_off_txd",  cnt_txd_low(0, ts, te - 1), 0);
    lit("en_on_stb", 2, 0, te, 1'b1);
    chk_int("en_drop_stb0", cnt_stb(0, te, te + 59), 1);
    chk_int("en_drop_stb2", cnt_stb(2, te, te + 59), 1);

    // Reset during a low data bit (C3 bit2 = 0).
    t0 = cyc; d = 8'hC3; d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    repeat (13) tick();
    chk("pre_rst_txd", txd_v[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_txd0",  txd_v[0],  1'b1);
    chk("rst_busy0", busy_v[0], 1'b0);
    chk("rst_txd2",  txd_v[2],  1'b1);
    chk("rst_busy2", busy_v[2], 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();
    t1 = cyc; d = 8'h0F; d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    repeat (50) tick();
    lit("rr_idle",     0, 0, t1,      1'b1);
    lit("rr_start_a",  0, 0, t1 + 1,  1'b0);
    lit("rr_start_b",  0, 0, t1 + 4,  1'b0);
    lit("rr_bit0",     0, 0, t1 + 5,  1'b1);
    lit("rr_busy",     1, 0, t1 + 40, 1'b1);
    lit("rr_busy_off", 1, 0, t1 + 41, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
